median_scan_ctrl: RTL and testbench

MEDIAN_SCAN_CTRL -- requirements
Module: median_scan_ctrl

---
 rtl/median_pkg.sv | 14 +
 rtl/median_scan_ctrl_raster_counter.sv | 40 ++++
 rtl/median_scan_ctrl.sv | 123 ++++++++++++
 tb/tb_median_scan_ctrl.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/median_pkg.sv
// Shared constants for the median filter scan controller: FSM state codes,
// default image geometry and pixel address width.
package median_pkg;
  localparam int ADDR_W        = 8;
  localparam int DEFAULT_IMG_W = 240;
  localparam int DEFAULT_IMG_H = 180;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SCAN  = 3'd1,
    DRAIN = 3'd2,
    DONE  = 3'd3
  } stateT;
endpackage

// File: rtl/median_scan_ctrl_raster_counter.sv
// Column-major raster counter (y inner, x outer); loads the first address,
// steps one window per advance, flags first/last address. Latency 1 cycle.
module raster_counter
  import median_pkg::*;
#(
  parameter logic [ADDR_W-1:0] X_FIRST = '0,
  parameter logic [ADDR_W-1:0] X_LAST  = ADDR_W'(DEFAULT_IMG_W - 1),
  parameter logic [ADDR_W-1:0] Y_FIRST = '0,
  parameter logic [ADDR_W-1:0] Y_LAST  = ADDR_W'(DEFAULT_IMG_H - 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              advance,
  output logic [ADDR_W-1:0] x,
  output logic [ADDR_W-1:0] y,
  output logic              isFirst,
  output logic              isLast
);
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x <= '0;
      y <= '0;
    end else if (load) begin
      x <= X_FIRST;
      y <= Y_FIRST;
    end else if (advance) begin
      if (y == Y_LAST) begin
        y <= Y_FIRST;
        // After the final window the counter parks back at the first address.
        x <= isLast ? X_FIRST : x + 1'b1;
      end else begin
        y <= y + 1'b1;
      end
    end
  end

  assign isFirst = (x == X_FIRST) && (y == Y_FIRST);
  assign isLast  = (x == X_LAST)  && (y == Y_LAST);
endmodule

// File: rtl/median_scan_ctrl.sv
// Median scan controller: host pixel writes in IDLE, raster window requests to the engine on start;
// engX/engY held while engAck low, DRAIN waits on engBusy. MEDIAN_BORDER_SKIP_EN skips the 1-pixel border.
module median_scan_ctrl
  import median_pkg::*;
#(
  parameter int IMG_W = DEFAULT_IMG_W,
  parameter int IMG_H = DEFAULT_IMG_H
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              writeMem,
  input  logic [ADDR_W-1:0] xAddressIn,
  input  logic [ADDR_W-1:0] yAddressIn,
  input  logic              engAck,
  input  logic              engBusy,
  output logic              memWrite,
  output logic [ADDR_W-1:0] memX,
  output logic [ADDR_W-1:0] memY,
  output logic              engReq,
  output logic [ADDR_W-1:0] engX,
  output logic [ADDR_W-1:0] engY,
  output logic [2:0]        state,
  output logic              writeReject,
  output logic              fullImageDone,
  output logic [15:0]       windowCount
);
`ifdef MEDIAN_BORDER_SKIP_EN
  localparam logic [ADDR_W-1:0] X_FIRST = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] X_LAST  = ADDR_W'(IMG_W - 2);
  localparam logic [ADDR_W-1:0] Y_FIRST = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] Y_LAST  = ADDR_W'(IMG_H - 2);
`else
  localparam logic [ADDR_W-1:0] X_FIRST = '0;
  localparam logic [ADDR_W-1:0] X_LAST  = ADDR_W'(IMG_W - 1);
  localparam logic [ADDR_W-1:0] Y_FIRST = '0;
  localparam logic [ADDR_W-1:0] Y_LAST  = ADDR_W'(IMG_H - 1);
`endif

  stateT             curState, nxtState;
  logic              startQ, startEdge, accept, scanLoad, scanFirst, scanLast;
  logic [ADDR_W-1:0] scanX, scanY;

  assign startEdge = start & ~startQ;
  assign accept    = (curState == SCAN) & engAck;
  assign scanLoad  = (curState == IDLE) & startEdge;

  raster_counter #(
    .X_FIRST(X_FIRST), .X_LAST(X_LAST), .Y_FIRST(Y_FIRST), .Y_LAST(Y_LAST)
  ) uRaster (
    .clk    (clk),
    .reset  (reset),
    .load   (scanLoad),
    .advance(accept),
    .x      (scanX),
    .y      (scanY),
    .isFirst(scanFirst),
    .isLast (scanLast)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      curState    <= IDLE;
      startQ      <= 1'b0;
      windowCount <= '0;
    end else begin
      curState <= nxtState;
      startQ   <= start;
      if (scanLoad)
        windowCount <= '0;
      else if (accept)
        // The first window of a pass always counts as one, independent of history.
        windowCount <= scanFirst ? 16'd1
                     : (windowCount == 16'hFFFF) ? windowCount : windowCount + 16'd1;
    end
  end

  always_comb begin
    nxtState      = curState;
    memWrite      = 1'b0;
    memX          = scanX;
    memY          = scanY;
    engReq        = 1'b0;
    writeReject   = 1'b0;
    fullImageDone = 1'b0;
    case (curState)
      IDLE: begin
        memX = xAddressIn;
        memY = yAddressIn;
        // A start edge wins over a same-cycle host write.
        if (startEdge) begin
          nxtState    = SCAN;
          writeReject = writeMem;
        end else begin
          memWrite = writeMem;
        end
      end
      SCAN: begin
        engReq      = 1'b1;
        writeReject = writeMem;
        if (accept && scanLast) nxtState = DRAIN;
      end
      DRAIN: begin
        writeReject = writeMem;
        if (!engBusy) nxtState = DONE;
      end
      DONE: begin
        writeReject   = writeMem;
        fullImageDone = 1'b1;
        nxtState      = IDLE;
      end
      default: nxtState = IDLE;
    endcase
    if (reset) begin
      memWrite    = 1'b0;
      writeReject = 1'b0;
    end
  end

  assign engX  = scanX;
  assign engY  = scanY;
  assign state = curState;
endmodule

// File: tb/tb_median_scan_ctrl.sv
// Directed-plus-random bench for median_scan_ctrl; expected window addresses come
// from the linear window index (x = first + k / rows, y = first + k % rows).
module tb_median_scan_ctrl;
  localparam int W = 240;
  localparam int H = 180;
`ifdef MEDIAN_BORDER_SKIP_EN
  localparam int XF = 1, XL = W - 2, YF = 1, YL = H - 2;
`else
  localparam int XF = 0, XL = W - 1, YF = 0, YL = H - 1;
`endif
  localparam int NY     = YL - YF + 1;
  localparam int PASS   = (XL - XF + 1) * NY;
  localparam int BUDGET = 80000;

  logic       clk = 1'b0;
  logic       reset, start, writeMem, engAck, engBusy;
  logic [7:0] xAddressIn, yAddressIn;
  logic       memWrite, engReq, writeReject, fullImageDone;
  logic [7:0] memX, memY, engX, engY;
  logic [2:0] state;
  logic [15:0] windowCount;

  int nCmp = 0;
  int nErr = 0;

  median_scan_ctrl #(.IMG_W(W), .IMG_H(H)) dut (
    .clk(clk), .reset(reset), .start(start), .writeMem(writeMem),
    .xAddressIn(xAddressIn), .yAddressIn(yAddressIn),
    .engAck(engAck), .engBusy(engBusy),
    .memWrite(memWrite), .memX(memX), .memY(memY),
    .engReq(engReq), .engX(engX), .engY(engY), .state(state),
    .writeReject(writeReject), .fullImageDone(fullImageDone),
    .windowCount(windowCount)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nCmp++;
    assert (obs === exp)
    else begin
      nErr++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int  k, cyc, holdLeft, expCnt;
    logic ack, wm;
    bit  doneSeen;

    reset = 1'b1; start = 1'b0; writeMem = 1'b1; engAck = 1'b0; engBusy = 1'b0;
    xAddressIn = 8'd0; yAddressIn = 8'd0;
    step(); step();
    chk("rst_state", state, 0);
    chk("rst_engReq", engReq, 0);
    chk("rst_memWrite", memWrite, 0);
    chk("rst_writeReject", writeReject, 0);
    chk("rst_done", fullImageDone, 0);
    chk("rst_count", windowCount, 0);
    chk("rst_engX", engX, 0);
    chk("rst_engY", engY, 0);

    reset = 1'b0;
    writeMem = 1'b1; xAddressIn = 8'd5; yAddressIn = 8'd7;
    #1;
    chk("idle_memWrite", memWrite, 1);
    chk("idle_memX", memX, 5);
    chk("idle_memY", memY, 7);
    chk("idle_writeReject", writeReject, 0);
    chk("idle_engReq", engReq, 0);

    // engAck outside SCAN must not count
    writeMem = 1'b0; engAck = 1'b1;
    step();
    chk("idle_ack_ignored", windowCount, 0);
    chk("idle_state", state, 0);

    start = 1'b1; writeMem = 1'b1; engAck = 1'b0;
    #1;
    chk("startwr_reject", writeReject, 1);
    chk("startwr_memWrite", memWrite, 0);
    step();
    chk("scan_entry_state", state, 1);
    chk("scan_first_x", engX, XF);
    chk("scan_first_y", engY, YF);
    chk("scan_entry_count", windowCount, 0);

    k = 0; cyc = 0; holdLeft = 3;
    while (k < PASS && cyc < BUDGET) begin
      ack = ($urandom_range(0, 7) != 0);
      if (k == NY - 1 && holdLeft > 0) begin
        ack = 1'b0;
        holdLeft--;
      end
      wm = ($urandom_range(0, 15) == 0);
      engAck = ack; writeMem = wm;
      xAddressIn = 8'($urandom); yAddressIn = 8'($urandom);
      start = 1'($urandom_range(0, 1));
      #1;
      chk("scan_engX", engX, XF + k / NY);
      chk("scan_engY", engY, YF + k % NY);
      chk("scan_memX", memX, XF + k / NY);
      chk("scan_memY", memY, YF + k % NY);
      chk("scan_engReq", engReq, 1);
      chk("scan_memWrite", memWrite, 0);
      chk("scan_writeReject", writeReject, wm);
      chk("scan_state", state, 1);
      chk("scan_count", windowCount, (k > 65535) ? 65535 : k);
      chk("scan_done", fullImageDone, 0);
      if (k == NY - 1 && holdLeft == 0 && !ack) begin
        chk("hold_engX", engX, XF);
        chk("hold_engY", engY, YL);
      end
      if (k == NY) begin
        chk("wrap_engX", engX, XF + 1);
        chk("wrap_engY", engY, YF);
      end
      step();
      if (ack) k++;
      cyc++;
    end
    chk("pass_accepts", k, PASS);

    engBusy = 1'b1; engAck = 1'b1; writeMem = 1'b0; start = 1'b1;
    repeat (20) begin
      #1;
      chk("drain_state", state, 2);
      chk("drain_engReq", engReq, 0);
      chk("drain_done", fullImageDone, 0);
      chk("drain_count", windowCount, PASS);
      step();
    end
    engBusy = 1'b0;
    #1;
    chk("drain_tail_state", state, 2);
    step();
    chk("done_state", state, 3);
    chk("done_pulse", fullImageDone, 1);
    chk("done_count", windowCount, PASS);
    writeMem = 1'b1;
    #1;
    chk("done_writeReject", writeReject, 1);
    chk("done_memWrite", memWrite, 0);
    step();
    writeMem = 1'b0;
    chk("post_state", state, 0);
    chk("post_done", fullImageDone, 0);
    chk("post_engReq", engReq, 0);
    repeat (5) begin
      step();
      chk("held_start_state", state, 0);
      chk("held_start_count", windowCount, PASS);
    end

    start = 1'b0; engAck = 1'b1;
    step();
    start = 1'b1;
    step();
    chk("pass2_state", state, 1);
    repeat (300) step();
    expCnt = 300;
    chk("pass2_count", windowCount, expCnt);
    chk("pass2_engX", engX, XF + expCnt / NY);
    chk("pass2_engY", engY, YF + expCnt % NY);

    reset = 1'b1; start = 1'b0;
    #1;
    chk("midrst_state", state, 0);
    chk("midrst_count", windowCount, 0);
    chk("midrst_engReq", engReq, 0);
    chk("midrst_engX", engX, 0);
    chk("midrst_done", fullImageDone, 0);
    step();
    reset = 1'b0;
    doneSeen = 1'b0;
    repeat (50) begin
      step();
      if (fullImageDone) doneSeen = 1'b1;
    end
    chk("midrst_no_done", doneSeen, 0);
    chk("midrst_idle", state, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
    $finish;
  end
endmodule
